// File: rtl/click_seq_pkg.sv
// Shared types and default sizing for the click window sequencer.
package click_seq_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 16;
    localparam int LW_DEF  = 24;
    localparam int SW_DEF  = 8;
    localparam int DROP_W  = 8;

    // Largest value a default-width live counter can hold before it sticks.
    localparam int unsigned SAT_MAX = (1 << CW_DEF) - 1;

    typedef enum logic {
        ST_IDLE,
        ST_COUNT
    } seq_state_t;

endpackage

// File: rtl/click_sat_counter.sv
// One live pulse counter: clears to zero, or loads its own value plus the
// incoming pulse, sticking at all-ones.
module click_sat_counter
    import click_seq_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          enable,
    input  logic          inc,
    output logic [CW-1:0] value_next
);

    localparam logic [CW-1:0] MAX = {CW{1'b1}};
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] count;

    // value_next is exposed so the owner can snapshot the count that
    // includes this cycle's pulse without waiting a cycle.
    always_comb begin
        value_next = count;
        if (inc && (count != MAX)) begin
            value_next = count + ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= value_next;
        end
    end

endmodule

// File: rtl/click_window_sequencer.sv
// Gate-window pulse counter with a single-entry readout buffer, back-to-back
// windows, abort, and sticky overrun reporting.
module click_window_sequencer
    import click_seq_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int LW  = LW_DEF,
    parameter int SW  = SW_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NCH-1:0]    pulse,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [LW-1:0]     window_len,
    input  logic              clear_overrun,
    output logic [NCH*CW-1:0] counts,
    output logic [SW-1:0]     seq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        dropped
);

    localparam logic [LW-1:0]     LEN_ONE  = LW'(1);
    localparam logic [SW-1:0]     SEQ_ONE  = SW'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    seq_state_t state, state_next;

    logic [LW-1:0]     timer;
    logic [LW-1:0]     len_eff;
    logic [NCH*CW-1:0] live_next;
    logic              cnt_clear;
    logic              cnt_en;
    logic              win_end;
    logic              timer_load;
    logic              buf_free;
    logic              buf_load;
    logic              drop_evt;

    assign len_eff  = (window_len == '0) ? LEN_ONE : window_len;
    assign buf_free = !out_valid || out_ready;
    assign buf_load = win_end && buf_free;
    assign drop_evt = win_end && !buf_free;
    assign busy     = (state == ST_COUNT);

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        click_sat_counter #(
            .CW(CW)
        ) u_cnt (
            .clock      (clock),
            .reset_n    (reset_n),
            .clear      (cnt_clear),
            .enable     (cnt_en),
            .inc        (pulse[i]),
            .value_next (live_next[i*CW +: CW])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stop outranks the end event; a continuous restart clears the counters
    // on the last cycle so the next cycle is already window cycle 1.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        win_end    = 1'b0;
        timer_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_COUNT;
                    cnt_clear  = 1'b1;
                    timer_load = 1'b1;
                end
            end
            ST_COUNT: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (timer == LEN_ONE) begin
                        win_end = 1'b1;
                        if (continuous) begin
                            cnt_clear  = 1'b1;
                            timer_load = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (timer_load) begin
            timer <= len_eff;
        end else if (state_next == ST_IDLE) begin
            timer <= '0;
        end else if (state == ST_COUNT) begin
            timer <= timer - LEN_ONE;
        end
    end

    // A load in the same cycle as an acceptance keeps out_valid high with the
    // new window, so the reader never sees a gap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counts    <= '0;
            seq       <= '0;
            out_valid <= 1'b0;
        end else if (buf_load) begin
            counts    <= live_next;
            seq       <= seq + SEQ_ONE;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A drop coinciding with a clear restarts the tally at one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
            dropped <= '0;
        end else if (drop_evt) begin
            overrun <= 1'b1;
            if (clear_overrun) begin
                dropped <= DROP_ONE;
            end else if (dropped != DROP_MAX) begin
                dropped <= dropped + DROP_ONE;
            end
        end else if (clear_overrun) begin
            overrun <= 1'b0;
            dropped <= '0;
        end
    end

endmodule

// File: tb/tb_click_window_sequencer.sv
// Randomized bench for click_window_sequencer against a window-deadline
// reference model that tracks absolute cycle numbers.
module tb_click_window_sequencer;

    localparam int NCH  = 4;
    localparam int CW   = 4;
    localparam int LW   = 24;
    localparam int SW   = 8;
    localparam int SATV = (1 << CW) - 1;

    typedef struct {
        int cycles;
        int p_pulse;
        int p_ready;
        int p_start;
        int p_stop;
        int p_cont;
        int p_clr;
        int max_len;
    } phase_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    pulse = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic [LW-1:0]     window_len = '0;
    logic              clear_overrun = 1'b0;
    logic              out_ready = 1'b0;
    logic [NCH*CW-1:0] counts;
    logic [SW-1:0]     seq;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    logic [7:0]        dropped;

    click_window_sequencer #(
        .NCH(NCH), .CW(CW), .LW(LW), .SW(SW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pulse         (pulse),
        .start         (start),
        .stop          (stop),
        .continuous    (continuous),
        .window_len    (window_len),
        .clear_overrun (clear_overrun),
        .counts        (counts),
        .seq           (seq),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .overrun       (overrun),
        .dropped       (dropped)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;

    int     m_live [NCH];
    int     m_buf  [NCH];
    int     m_seq;
    int     m_drop;
    bit     m_valid;
    bit     m_inwin;
    bit     m_ovr;
    longint cyc;
    longint m_end;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            m_live[i] = 0;
            m_buf[i]  = 0;
        end
        m_seq   = 0;
        m_drop  = 0;
        m_valid = 0;
        m_inwin = 0;
        m_ovr   = 0;
        m_end   = 0;
    endtask

    // Advances the model across one rising edge using the inputs now driven.
    task automatic modelStep();
        bit accept;
        bit loaded;
        bit drop_now;
        int len;
        accept   = m_valid && out_ready;
        loaded   = 0;
        drop_now = 0;
        len      = (window_len == '0) ? 1 : int'(window_len);
        if (!m_inwin) begin
            if (start) begin
                m_inwin = 1;
                m_end   = cyc + len;
                for (int i = 0; i < NCH; i++) m_live[i] = 0;
            end
        end else if (stop) begin
            m_inwin = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                m_live[i] = m_live[i] + int'(pulse[i]);
                if (m_live[i] > SATV) m_live[i] = SATV;
            end
            if (cyc == m_end) begin
                if (!m_valid || accept) begin
                    for (int i = 0; i < NCH; i++) m_buf[i] = m_live[i];
                    m_seq  = (m_seq + 1) % (1 << SW);
                    loaded = 1;
                end else begin
                    drop_now = 1;
                end
                if (continuous) begin
                    m_end = cyc + len;
                    for (int i = 0; i < NCH; i++) m_live[i] = 0;
                end else begin
                    m_inwin = 0;
                end
            end
        end
        if (loaded) m_valid = 1;
        else if (accept) m_valid = 0;
        if (drop_now) begin
            m_ovr  = 1;
            m_drop = clear_overrun ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clear_overrun) begin
            m_ovr  = 0;
            m_drop = 0;
        end
        cyc++;
    endtask

    task automatic compareAll();
        logic [NCH*CW-1:0] exp_counts;
        for (int i = 0; i < NCH; i++) exp_counts[i*CW +: CW] = CW'(m_buf[i]);
        checkOutput("counts",    64'(counts),    64'(exp_counts));
        checkOutput("seq",       64'(seq),       64'(m_seq));
        checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("busy",      64'(busy),      64'(m_inwin));
        checkOutput("overrun",   64'(overrun),   64'(m_ovr));
        checkOutput("dropped",   64'(dropped),   64'(m_drop));
    endtask

    task automatic applyStimulus(input phase_t ph);
        for (int i = 0; i < NCH; i++) pulse[i] = ($urandom_range(0, 99) < ph.p_pulse);
        out_ready     = ($urandom_range(0, 99) < ph.p_ready);
        start         = ($urandom_range(0, 99) < ph.p_start);
        stop          = ($urandom_range(0, 99) < ph.p_stop);
        continuous    = ($urandom_range(0, 99) < ph.p_cont);
        clear_overrun = ($urandom_range(0, 99) < ph.p_clr);
        window_len    = LW'($urandom_range(0, ph.max_len));
    endtask

    task automatic runPhase(input phase_t ph);
        for (int c = 0; c < ph.cycles; c++) begin
            @(negedge clock);
            compareAll();
            applyStimulus(ph);
            modelStep();
        end
    endtask

    phase_t phases [6] = '{
        '{400, 30,  80,  30, 2,  50,   3, 12},
        '{300, 90,  20,  50, 1,  70,   5, 25},
        '{400, 50,   0, 100, 0, 100,   0,  1},
        '{ 50, 10, 100,   0, 0,   0, 100,  4},
        '{600, 40, 100, 100, 0, 100,   2,  1},
        '{300, 40,  60,  20, 5,  30,   3,  8}
    };
    phase_t force_idle = '{3, 0, 100, 0, 100, 0, 0, 4};
    phase_t idle_quiet = '{4, 0, 100, 0, 0, 0, 0, 4};
    phase_t after_rst  = '{300, 35, 70, 30, 2, 40, 3, 10};

    initial begin
        cyc = 0;
        modelReset();
        repeat (3) @(negedge clock);
        compareAll();
        reset_n = 1'b1;

        foreach (phases[p]) runPhase(phases[p]);

        // Open a long window, then pull reset asynchronously part-way in.
        runPhase(force_idle);
        runPhase(idle_quiet);
        @(negedge clock);
        compareAll();
        applyStimulus(idle_quiet);
        start      = 1'b1;
        window_len = LW'(20);
        modelStep();
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            compareAll();
            applyStimulus(idle_quiet);
            pulse = NCH'($urandom);
            modelStep();
        end
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(negedge clock);
        compareAll();
        reset_n = 1'b1;
        applyStimulus(after_rst);
        modelStep();
        runPhase(after_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/click_window_sequencer.md
# click_window_sequencer

Gating and readout sequencer for the pulse-registration front end. Takes single-cycle edge pulses from the per-channel edge detectors, counts them per channel inside a programmable gate window, and snapshots the counts into an output buffer. The buffer is drained by the readout side over a valid/ready handshake. Supports single-shot and back-to-back (zero dead-time) windows, abort, and sticky overrun reporting when readout falls behind.

## Interface
- NCH, 4: number of pulse channels
- CW, 16: per-channel count width (saturating)
- LW, 24: window-length width
- SW, 8: window sequence-number width
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pulse  in  NCH  one-cycle-per-edge pulses from the edge detectors, synchronous to clock
- start  in  1  begin a window; honoured only in IDLE
- stop  in  1  abort current window and leave continuous mode
- continuous  in  1  sampled at window end; 1 = start next window immediately
- window_len  in  LW  gate length in cycles; sampled on start and on each continuous restart; 0 treated as 1
- clear_overrun  in  1  clears overrun and dropped
- counts  out  NCH*CW  buffered counts, channel i at [i*CW +: CW]
- seq  out  SW  sequence number of buffered window, wraps
- out_valid  out  1  buffer holds unread window
- out_ready  in  1  readout accepts buffer when out_valid & out_ready
- busy  out  1  high in COUNT
- overrun  out  1  sticky: a finished window was dropped
- dropped  out  8  saturating count of dropped windows

## Operation
- States: IDLE, COUNT. Encoding is free; reset state is IDLE.
- IDLE, start=1: load timer with max(window_len,1), clear live counters, go to COUNT.
- COUNT, each cycle: live counter i += pulse[i], saturating at 2^CW-1; timer decrements.
- Last window cycle (timer==1) is the end event:
  - Buffer is free if out_valid==0, or out_valid&out_ready in the same cycle. If free: counts <= live counts including this cycle's pulses, seq <= seq+1 (first window = 1), out_valid <= 1.
  - Else: window is discarded, overrun <= 1, dropped <= dropped+1 (saturating at 255). The existing buffer is untouched.
  - continuous=1: remain in COUNT, reload timer from window_len, live counter i <= pulse-free 0 for the new window. There is no dead cycle: the next cycle is window cycle 1.
  - continuous=0: go to IDLE.
- stop in COUNT has priority over the end event. It discards the live counts, makes no buffer write, and goes to IDLE next cycle. stop in IDLE has no effect.
- start in COUNT is ignored.
- Handshake: out_valid falls the cycle after out_valid&out_ready unless a new window loads in that same cycle, in which case it stays 1 with new data. counts and seq are stable while out_valid=1 and unaccepted.
- clear_overrun and an overrun event in the same cycle: the event wins (overrun=1, dropped=1).
- Reset mid-window: everything returns to reset values asynchronously. No partial window is reported.

## Timing
- Reset values: counts=0, seq=0, out_valid=0, busy=0, overrun=0, dropped=0, state IDLE, timer 0.
- start sampled at cycle t. Window cycles are t+1..t+L (busy=1). Pulses in exactly those cycles are counted.
- out_valid=1 and counts updated at t+L+1 (latency 1 cycle from the last window cycle).
- Continuous: window k spans t+1+(k-1)L .. t+kL. Every pulse is counted in exactly one window.
- busy falls at t+L+1 (non-continuous) or the cycle after stop.

## Structure
- Package click_seq_pkg holds the state enum, default widths and the SAT_MAX helper constant.
- One sub-module, click_sat_counter (CW-bit, with clear, load-with-increment and saturate), is instantiated NCH times for the live counters.
- Output buffer, timer, seq and overrun logic stay in the top module.

## Test plan
- Single shot: L=10, pulses ch0 ×3 and ch2 ×7 in window, out_ready=1 → out_valid at t+11, counts {0,7,0,3} (ch3..ch0), seq=1, busy low at t+11.
- Boundary sampling: L=5, pulses on ch1 at t (before window), t+1, t+5, and t+6 → count 2.
- Continuous, no dead time: L=4, ch0 pulses every cycle for 12 cycles, out_ready=1 → three windows of 4 each, seq 1,2,3, no overrun.
- Overrun: continuous L=3, out_ready=0 → window 1 buffered; windows 2 and 3 dropped; overrun=1, dropped=2, counts/seq unchanged. Then clear_overrun → 0/0.
- Saturation and stop: CW=4, 20 pulses in L=25 → count 15. Second run stopped at cycle 3 → no out_valid, busy falls next cycle.
- Async reset asserted mid-COUNT → all outputs at reset values immediately. A new start after release behaves as the first window, with seq=1.
